// File: rtl/mul_csa_reduce_sequencer_pkg.sv
// rtl/mul_csa_reduce_sequencer_pkg.sv - shared sizes, state type and circular pointer helper
package mul_pkg;
  localparam int MANT_W    = 24;
  localparam int PROD_W    = 2 * MANT_W;
  localparam int ROW_CNT_W = $clog2(MANT_W + 1);
  localparam int PTR_W     = $clog2(MANT_W);

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} stateT;

  // Row-buffer slots are not a power of two, so pointers wrap explicitly at MANT_W.
  function automatic logic [PTR_W-1:0] ptrAdd(input logic [PTR_W-1:0] ptr, input logic [1:0] inc);
    logic [PTR_W:0] sum;
    sum = {1'b0, ptr} + {{(PTR_W-1){1'b0}}, inc};
    if (sum >= (PTR_W+1)'(MANT_W)) sum = sum - (PTR_W+1)'(MANT_W);
    return sum[PTR_W-1:0];
  endfunction
endpackage

// File: rtl/mul_csa_reduce_sequencer_if.sv
// rtl/mul_csa_reduce_sequencer_if.sv - operand/result handshake bundle for the CSA sequencer
interface mul_csa_reduce_sequencer_if;
  import mul_pkg::*;
  logic              InValid;
  logic              InReady;
  logic [MANT_W-1:0] OperandA;
  logic [MANT_W-1:0] OperandB;
  logic              OutValid;
  logic              OutReady;
  logic [PROD_W-1:0] ProductSum;
  logic [PROD_W-1:0] ProductCarry;
  logic              Busy;

  modport master (output InValid, OperandA, OperandB, OutReady,
                  input  InReady, OutValid, ProductSum, ProductCarry, Busy);
  modport slave  (input  InValid, OperandA, OperandB, OutReady,
                  output InReady, OutValid, ProductSum, ProductCarry, Busy);
endinterface

// File: rtl/mul_csa_reduce_sequencer_csa_row_compressor.sv
// rtl/mul_csa_reduce_sequencer_csa_row_compressor.sv - combinational 3:2 row compressor from full adders
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// Carry is returned unshifted; the caller applies the weight-2 shift.
module csa_row_compressor import mul_pkg::*; (
  input  logic [PROD_W-1:0] x,
  input  logic [PROD_W-1:0] y,
  input  logic [PROD_W-1:0] z,
  output logic [PROD_W-1:0] sum,
  output logic [PROD_W-1:0] carry
);
  for (genvar i = 0; i < PROD_W; i++) begin : gFa
    FullAdder uFa (.a(x[i]), .b(y[i]), .cin(z[i]), .sum(sum[i]), .cout(carry[i]));
  end
endmodule

// File: rtl/mul_csa_reduce_sequencer.sv
// rtl/mul_csa_reduce_sequencer.sv - time-shared CSA reduction of mantissa partial products (option: MUL_ZERO_SKIP_EN)
module mul_csa_reduce_sequencer import mul_pkg::*; (
  input logic                        Clk,
  input logic                        Reset_n,
  mul_csa_reduce_sequencer_if.slave  bus
);
  stateT                 state, nextState;
  logic [PTR_W-1:0]      head, tail;
  logic [ROW_CNT_W-1:0]  count;
  logic [PROD_W-1:0]     rowBuf [MANT_W];
  logic [PROD_W-1:0]     rowX, rowY, rowZ, csaSum, csaCarry, carryShifted;
  logic [PROD_W-1:0]     productSum, productCarry;
  logic                  accept, step, zeroSkip;

  assign rowX = rowBuf[head];
  assign rowY = rowBuf[ptrAdd(head, 2'd1)];
  assign rowZ = rowBuf[ptrAdd(head, 2'd2)];
  assign carryShifted = csaCarry << 1;

  csa_row_compressor uCsa (.x(rowX), .y(rowY), .z(rowZ), .sum(csaSum), .carry(csaCarry));

  assign accept = (state == IDLE) && bus.InValid;
  assign step   = (state == REDUCE);

`ifdef MUL_ZERO_SKIP_EN
  assign zeroSkip = (bus.OperandA == '0) || (bus.OperandB == '0);
`else
  assign zeroSkip = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState    = state;
    bus.InReady  = 1'b0;
    bus.OutValid = 1'b0;
    bus.Busy     = 1'b0;
    case (state)
      IDLE: begin
        bus.InReady = 1'b1;
        if (bus.InValid) nextState = zeroSkip ? DONE : REDUCE;
      end
      REDUCE: begin
        bus.Busy = 1'b1;
        if (count == ROW_CNT_W'(3)) nextState = DONE;
      end
      DONE: begin
        bus.Busy     = 1'b1;
        bus.OutValid = 1'b1;
        if (bus.OutReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      productSum   <= '0;
      productCarry <= '0;
    end else if (accept) begin
      head  <= '0;
      tail  <= '0;
      count <= ROW_CNT_W'(MANT_W);
      if (zeroSkip) begin
        productSum   <= '0;
        productCarry <= '0;
      end
    end else if (step) begin
      head  <= ptrAdd(head, 2'd3);
      tail  <= ptrAdd(tail, 2'd2);
      count <= count - ROW_CNT_W'(1);
      if (count == ROW_CNT_W'(3)) begin
        productSum   <= csaSum;
        productCarry <= carryShifted;
      end
    end
  end

  // Buffer contents are don't-care after reset, so this storage has no reset.
  always_ff @(posedge Clk) begin
    if (accept) begin
      for (int i = 0; i < MANT_W; i++)
        rowBuf[i] <= bus.OperandB[i] ? (PROD_W'(bus.OperandA) << i) : '0;
    end else if (step) begin
      rowBuf[tail]              <= csaSum;
      rowBuf[ptrAdd(tail, 2'd1)] <= carryShifted;
    end
  end

  assign bus.ProductSum   = productSum;
  assign bus.ProductCarry = productCarry;
endmodule

// File: tb/tb_mul_csa_reduce_sequencer.sv
// tb/tb_mul_csa_reduce_sequencer.sv - self-checking bench for mul_csa_reduce_sequencer (honours MUL_ZERO_SKIP_EN)
module tb_mul_csa_reduce_sequencer;
  import mul_pkg::*;
`ifdef MUL_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  mul_csa_reduce_sequencer_if bus();
  mul_csa_reduce_sequencer dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: an operation is idle, counting down its fixed latency, or presenting A*B.
  logic              mIdle = 1'b1;
  logic              mValid = 1'b0;
  int                mLeft = 0;
  logic [PROD_W-1:0] mProd = '0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mIdle  <= 1'b1;
      mValid <= 1'b0;
      mLeft  <= 0;
    end else if (mIdle) begin
      if (bus.InValid) begin
        mIdle <= 1'b0;
        mProd <= PROD_W'(bus.OperandA) * PROD_W'(bus.OperandB);
        if (ZERO_SKIP && (bus.OperandA == 0 || bus.OperandB == 0)) mValid <= 1'b1;
        else mLeft <= MANT_W - 2;
      end
    end else if (!mValid) begin
      mLeft <= mLeft - 1;
      if (mLeft == 1) mValid <= 1'b1;
    end else if (bus.OutReady) begin
      mValid <= 1'b0;
      mIdle  <= 1'b1;
    end
  end

  logic              checkEn = 1'b0;
  logic              prevValid = 1'b0;
  logic [PROD_W-1:0] prevSum = '0, prevCarry = '0;

  always @(negedge Clk) begin
    if (checkEn) begin
      check("InReady", bus.InReady, mIdle);
      check("Busy", bus.Busy, !mIdle);
      check("OutValid", bus.OutValid, mValid);
      if (mValid) begin
        check("result", PROD_W'(bus.ProductSum + bus.ProductCarry), mProd);
        if (prevValid) begin
          check("holdSum", bus.ProductSum, prevSum);
          check("holdCarry", bus.ProductCarry, prevCarry);
        end
      end
      prevValid <= mValid && bus.OutValid;
      prevSum   <= bus.ProductSum;
      prevCarry <= bus.ProductCarry;
    end
  end

  task automatic runOp(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b, input int hold,
                       input bit pokeInValid, output int lat, output logic [PROD_W-1:0] res);
    bus.OperandA = a;
    bus.OperandB = b;
    bus.InValid  = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid  = pokeInValid;
    bus.OperandA = ~a;
    bus.OperandB = ~b;
    lat = 0;
    while (!bus.OutValid && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
    res = PROD_W'(bus.ProductSum + bus.ProductCarry);
    repeat (hold) begin
      @(negedge Clk);
      check("holdInReady", bus.InReady, 1'b0);
    end
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    @(negedge Clk);
    bus.OutReady = 1'b0;
    check("dropValid", bus.OutValid, 1'b0);
    check("backIdle", bus.InReady, 1'b1);
  endtask

  int lat;
  logic [PROD_W-1:0] res;

  initial begin
    bus.InValid  = 1'b0;
    bus.OperandA = '0;
    bus.OperandB = '0;
    bus.OutReady = 1'b0;
    #1 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("rstOutValid", bus.OutValid, 1'b0);
    check("rstBusy", bus.Busy, 1'b0);
    check("rstInReady", bus.InReady, 1'b1);
    check("rstSum", bus.ProductSum, 48'h0);
    check("rstCarry", bus.ProductCarry, 48'h0);
    Reset_n = 1'b1;
    checkEn = 1'b1;
    @(negedge Clk);

    runOp(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0, lat, res);
    check("latFull", lat, 22);
    check("resFull", res, 48'hFFFFFE000001);

    runOp(24'h800000, 24'h800000, 0, 1'b0, lat, res);
    check("resMsb", res, 48'h400000000000);

    runOp(24'hC00001, 24'h800003, 5, 1'b1, lat, res);
    check("latStall", lat, 22);
    check("resStall", res, 48'h600002C00003);

    bus.OperandA = 24'hFFFFFF;
    bus.OperandB = 24'hFFFFFF;
    bus.InValid  = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid = 1'b0;
    repeat (12) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("abortOutValid", bus.OutValid, 1'b0);
    check("abortInReady", bus.InReady, 1'b1);
    check("abortBusy", bus.Busy, 1'b0);
    @(posedge Clk);
    #2 Reset_n = 1'b1;
    @(negedge Clk);
    runOp(24'h000003, 24'h000005, 0, 1'b0, lat, res);
    check("latAfterAbort", lat, 22);
    check("resAfterAbort", res, 48'h00000000000F);

    runOp(24'h000000, 24'h123456, 0, 1'b0, lat, res);
    check("latZero", lat, ZERO_SKIP ? 0 : 22);
    check("resZero", res, 48'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
